// File: rtl/uart_tx_cfg.sv
// Runtime-configurable UART transmitter with a TX FIFO. Supports a programmable baud divisor,
// 5..DATA_WIDTH data bits, none/even/odd parity and 1 or 2 stop bits.
module uart_tx_cfg #(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int BAUD_W     = 16
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic [BAUD_W-1:0]             baud_div_i,
  input  logic [3:0]                    data_bits_i,
  input  logic [1:0]                    parity_i,
  input  logic                          stop2_i,
  input  logic                          tx_en_i,
  input  logic                          tx_we_i,
  input  logic [DATA_WIDTH-1:0]         din_i,
  output logic                          tx_bit_o,
  output logic                          busy_o,
  output logic                          empty_o,
  output logic                          full_o,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_cnt_o,
  output logic                          overflow_o
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [3:0] MIN_BITS = 4'd5;
  localparam logic [3:0] MAX_BITS = 4'(DATA_WIDTH);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;

  logic [1:0]            rst_sync;
  logic                  rst_int;

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [CNT_W-1:0]      cnt;

  logic [2:0]            state;
  logic [BAUD_W-1:0]     baud_cnt;
  logic [3:0]            bit_left;
  logic                  stop_left;

  logic [DATA_WIDTH-1:0] shreg;
  logic [BAUD_W-1:0]     div_l;
  logic [3:0]            nbits_l;
  logic                  par_en_l;
  logic                  par_bit_l;
  logic                  stop2_l;

  logic [DATA_WIDTH-1:0] head;
  logic [3:0]            nbits_new;
  logic [BAUD_W-1:0]     div_new;
  logic                  wr_acc;
  logic                  bit_end;
  logic                  start_frame;

  function automatic logic [3:0] clamp_bits(input logic [3:0] b);
    if (b < MIN_BITS)      return MIN_BITS;
    else if (b > MAX_BITS) return MAX_BITS;
    else                   return b;
  endfunction

  function automatic logic [BAUD_W-1:0] eff_div(input logic [BAUD_W-1:0] d);
    if (d == '0) return BAUD_W'(1);
    else         return d;
  endfunction

  // XOR of only the low n bits; bits above the frame width never reach the line.
  function automatic logic parity_of(input logic [DATA_WIDTH-1:0] d, input logic [3:0] n);
    logic p;
    p = 1'b0;
    for (int i = 0; i < DATA_WIDTH; i++) begin
      if (i < int'(n)) p = p ^ d[i];
    end
    return p;
  endfunction

  // Reset asserts immediately but releases only on a clock edge.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) rst_sync <= 2'b11;
    else       rst_sync <= {rst_sync[0], 1'b0};
  end
  assign rst_int = rst_sync[1];

  assign head        = mem[rd_ptr];
  assign nbits_new   = clamp_bits(data_bits_i);
  assign div_new     = eff_div(baud_div_i);
  assign empty_o     = (cnt == '0);
  assign full_o      = (cnt == CNT_W'(FIFO_DEPTH));
  assign fifo_cnt_o  = cnt;
  assign busy_o      = (state != S_IDLE);
  assign wr_acc      = tx_we_i & ~full_o;
  assign bit_end     = (baud_cnt == '0);
  // A new frame may start from IDLE or on the final cycle of the last stop bit.
  assign start_frame = tx_en_i & ~empty_o &
                       ((state == S_IDLE) | ((state == S_STOP) & bit_end & ~stop_left));

  always_ff @(posedge clk_i or posedge rst_int) begin
    if (rst_int) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      cnt        <= '0;
      overflow_o <= 1'b0;
    end else begin
      if (wr_acc)      wr_ptr <= wr_ptr + 1'b1;
      if (start_frame) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_acc, start_frame})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
      overflow_o <= tx_we_i & full_o;
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_acc) mem[wr_ptr] <= din_i;
  end

  always_ff @(posedge clk_i or posedge rst_int) begin
    if (rst_int) begin
      state     <= S_IDLE;
      tx_bit_o  <= 1'b1;
      baud_cnt  <= '0;
      bit_left  <= '0;
      stop_left <= 1'b0;
    end else if (start_frame) begin
      state    <= S_START;
      tx_bit_o <= 1'b0;
      baud_cnt <= div_new - 1'b1;
    end else begin
      case (state)
        S_IDLE: begin
          tx_bit_o <= 1'b1;
        end
        S_START: begin
          if (bit_end) begin
            state    <= S_DATA;
            tx_bit_o <= shreg[0];
            baud_cnt <= div_l - 1'b1;
            bit_left <= nbits_l - 1'b1;
          end else begin
            baud_cnt <= baud_cnt - 1'b1;
          end
        end
        S_DATA: begin
          if (bit_end) begin
            baud_cnt <= div_l - 1'b1;
            if (bit_left != '0) begin
              tx_bit_o <= shreg[0];
              bit_left <= bit_left - 1'b1;
            end else if (par_en_l) begin
              state    <= S_PARITY;
              tx_bit_o <= par_bit_l;
            end else begin
              state     <= S_STOP;
              tx_bit_o  <= 1'b1;
              stop_left <= stop2_l;
            end
          end else begin
            baud_cnt <= baud_cnt - 1'b1;
          end
        end
        S_PARITY: begin
          if (bit_end) begin
            state     <= S_STOP;
            tx_bit_o  <= 1'b1;
            stop_left <= stop2_l;
            baud_cnt  <= div_l - 1'b1;
          end else begin
            baud_cnt <= baud_cnt - 1'b1;
          end
        end
        S_STOP: begin
          if (bit_end) begin
            if (stop_left) begin
              stop_left <= 1'b0;
              baud_cnt  <= div_l - 1'b1;
            end else begin
              state    <= S_IDLE;
              tx_bit_o <= 1'b1;
            end
          end else begin
            baud_cnt <= baud_cnt - 1'b1;
          end
        end
        default: begin
          state    <= S_IDLE;
          tx_bit_o <= 1'b1;
        end
      endcase
    end
  end

  // Frame data and configuration snapshot; mid-frame input changes are ignored.
  always_ff @(posedge clk_i) begin
    if (start_frame) begin
      shreg     <= head;
      div_l     <= div_new;
      nbits_l   <= nbits_new;
      par_en_l  <= ^parity_i;
      par_bit_l <= parity_of(head, nbits_new) ^ parity_i[1];
      stop2_l   <= stop2_i;
    end else if (bit_end && ((state == S_START) || ((state == S_DATA) && (bit_left != '0)))) begin
      shreg <= shreg >> 1;
    end
  end

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Directed bench for uart_tx_cfg: frame formats, FIFO full/overflow, back-to-back frames,
// mid-frame control changes and asynchronous reset.
module tb_uart_tx_cfg;

  logic        clk;
  logic        rst;
  logic [15:0] baud_div;
  logic [3:0]  data_bits;
  logic [1:0]  parity;
  logic        stop2;
  logic        tx_en;
  logic        tx_we;
  logic [7:0]  din;
  logic        tx_bit;
  logic        busy;
  logic        empty;
  logic        full;
  logic [4:0]  fifo_cnt;
  logic        overflow;

  int tests = 0;
  int fails = 0;

  uart_tx_cfg #(.DATA_WIDTH(8), .FIFO_DEPTH(16), .BAUD_W(16)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .baud_div_i  (baud_div),
    .data_bits_i (data_bits),
    .parity_i    (parity),
    .stop2_i     (stop2),
    .tx_en_i     (tx_en),
    .tx_we_i     (tx_we),
    .din_i       (din),
    .tx_bit_o    (tx_bit),
    .busy_o      (busy),
    .empty_o     (empty),
    .full_o      (full),
    .fifo_cnt_o  (fifo_cnt),
    .overflow_o  (overflow)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_cfg(input logic [15:0] d, input logic [3:0] n, input logic [1:0] p, input logic s2);
    baud_div  = d;
    data_bits = n;
    parity    = p;
    stop2     = s2;
  endtask

  task automatic write_byte(input logic [7:0] d);
    din   = d;
    tx_we = 1'b1;
    step();
    tx_we = 1'b0;
  endtask

  task automatic wait_start(input string tag);
    int n;
    n = 0;
    while (tx_bit !== 1'b0 && n < 200) begin
      step();
      n++;
    end
    check(tag, {31'd0, tx_bit}, 32'd0);
  endtask

  // bits[i] is the i-th bit on the line (start bit first); act 1 drops tx_en, act 2 sets 5 data bits.
  task automatic check_frame(input string tag, input logic [15:0] bits, input int nb, input int div,
                             input int act_at, input int act);
    logic ok;
    int   cyc;
    ok  = 1'b1;
    cyc = 0;
    for (int i = 0; i < nb; i++) begin
      for (int c = 0; c < div; c++) begin
        if (cyc == act_at && act == 1) tx_en = 1'b0;
        if (cyc == act_at && act == 2) data_bits = 4'd5;
        if (tx_bit !== bits[i] || busy !== 1'b1) ok = 1'b0;
        cyc++;
        step();
      end
    end
    check(tag, {31'd0, ok}, 32'd1);
  endtask

  initial begin
    logic ok;
    int   ov;
    logic [7:0] d;

    rst   = 1'b1;
    tx_en = 1'b0;
    tx_we = 1'b0;
    din   = 8'h00;
    set_cfg(16'd4, 4'd8, 2'b00, 1'b0);
    #1;
    check("rst_tx", {31'd0, tx_bit}, 32'd1);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_empty", {31'd0, empty}, 32'd1);
    check("rst_full", {31'd0, full}, 32'd0);
    check("rst_cnt", {27'd0, fifo_cnt}, 32'd0);
    check("rst_ovf", {31'd0, overflow}, 32'd0);
    repeat (3) step();
    rst = 1'b0;
    repeat (4) step();

    // 8N1 div 4, 0x41
    tx_en = 1'b1;
    write_byte(8'h41);
    wait_start("8n1_start");
    check_frame("8n1_frame", 16'h0282, 10, 4, -1, 0);
    check("8n1_busy_end", {31'd0, busy}, 32'd0);
    check("8n1_tx_end", {31'd0, tx_bit}, 32'd1);

    // 7E1 div 3, 0x43
    set_cfg(16'd3, 4'd7, 2'b01, 1'b0);
    write_byte(8'h43);
    wait_start("7e1_start");
    check_frame("7e1_frame", 16'h0386, 10, 3, -1, 0);
    check("7e1_busy_end", {31'd0, busy}, 32'd0);

    // 8O2 div 2, 0x0A
    set_cfg(16'd2, 4'd8, 2'b10, 1'b1);
    write_byte(8'h0A);
    wait_start("8o2_start");
    check_frame("8o2_frame", 16'h0E14, 12, 2, -1, 0);
    check("8o2_busy_end", {31'd0, busy}, 32'd0);

    // FIFO fill with 17 writes, transmission disabled
    tx_en = 1'b0;
    set_cfg(16'd1, 4'd8, 2'b00, 1'b0);
    ov = 0;
    for (int i = 0; i < 17; i++) begin
      din   = (i == 16) ? 8'hFF : 8'(i * 13 + 5);
      tx_we = 1'b1;
      step();
      if (overflow === 1'b1) ov++;
    end
    tx_we = 1'b0;
    step();
    if (overflow === 1'b1) ov++;
    check("fifo_full", {31'd0, full}, 32'd1);
    check("fifo_cnt16", {27'd0, fifo_cnt}, 32'd16);
    check("fifo_ovf_pulses", ov, 32'd1);
    tx_en = 1'b1;
    wait_start("drain_start");
    for (int i = 0; i < 16; i++) begin
      d = 8'(i * 13 + 5);
      check_frame($sformatf("drain_%0d", i), {6'd0, 1'b1, d, 1'b0}, 10, 1, -1, 0);
    end
    check("drain_busy_end", {31'd0, busy}, 32'd0);
    ok = 1'b1;
    for (int i = 0; i < 15; i++) begin
      if (tx_bit !== 1'b1 || busy !== 1'b0) ok = 1'b0;
      step();
    end
    check("drain_no_17th", {31'd0, ok}, 32'd1);
    check("drain_empty", {31'd0, empty}, 32'd1);

    // Back-to-back 8N1 div 4
    tx_en = 1'b0;
    set_cfg(16'd4, 4'd8, 2'b00, 1'b0);
    write_byte(8'h41);
    write_byte(8'h42);
    write_byte(8'h43);
    write_byte(8'h0A);
    check("b2b_cnt4", {27'd0, fifo_cnt}, 32'd4);
    tx_en = 1'b1;
    wait_start("b2b_start");
    check_frame("b2b_f1", 16'h0282, 10, 4, -1, 0);
    check_frame("b2b_f2", 16'h0284, 10, 4, -1, 0);
    check_frame("b2b_f3", 16'h0286, 10, 4, -1, 0);
    check("b2b_empty_after_pop4", {31'd0, empty}, 32'd1);
    check_frame("b2b_f4", 16'h0214, 10, 4, -1, 0);
    check("b2b_busy_end", {31'd0, busy}, 32'd0);

    // tx_en dropped during DATA of frame 1
    tx_en = 1'b0;
    write_byte(8'h41);
    write_byte(8'h42);
    tx_en = 1'b1;
    wait_start("endrop_start");
    check_frame("endrop_frame", 16'h0282, 10, 4, 12, 1);
    ok = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (tx_bit !== 1'b1 || busy !== 1'b0) ok = 1'b0;
      step();
    end
    check("endrop_idle", {31'd0, ok}, 32'd1);
    check("endrop_cnt1", {27'd0, fifo_cnt}, 32'd1);

    // data_bits changed to 5 mid-frame: frame keeps 8 bits
    tx_en = 1'b1;
    wait_start("cfgchg_start");
    check_frame("cfgchg_frame", 16'h0284, 10, 4, 6, 2);
    check("cfgchg_busy_end", {31'd0, busy}, 32'd0);
    data_bits = 4'd8;

    // Reset during DATA
    tx_en = 1'b0;
    write_byte(8'h43);
    write_byte(8'h43);
    tx_en = 1'b1;
    wait_start("rstmid_start");
    repeat (13) step();
    check("rstmid_pre_tx", {31'd0, tx_bit}, 32'd0);
    rst = 1'b1;
    #1;
    check("rstmid_tx", {31'd0, tx_bit}, 32'd1);
    check("rstmid_busy", {31'd0, busy}, 32'd0);
    check("rstmid_empty", {31'd0, empty}, 32'd1);
    check("rstmid_cnt", {27'd0, fifo_cnt}, 32'd0);
    step();
    rst = 1'b0;
    repeat (10) step();
    check("rstmid_post_tx", {31'd0, tx_bit}, 32'd1);
    check("rstmid_post_busy", {31'd0, busy}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
